// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage controller.
// Holds the controller state encoding, transfer sizes and address wrap.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RDRAIN,
        ST_DONE
    } memst_e;

    localparam int SCALAR_BYTES = 2;
    localparam int VEC_BYTES    = 8;

    // Callers truncate the sum to their address width, which gives the wrap.
    function automatic logic [15:0] addr_wrap(
        input logic [15:0] base,
        input logic [15:0] i
    );
        return base + i;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences byte-wide scalar/vector loads and
// stores, stalls upstream while busy, and registers the writeback bundle.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int MEMO_LINES = 64,
    parameter int REGI_SIZE  = 16,
    parameter int VECT_SIZE  = 8,
    parameter int ELEM_SIZE  = 8,
    localparam int AW = $clog2(MEMO_LINES),
    localparam int DW = ELEM_SIZE * VECT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REGI_SIZE-1:0] ialu_res_i,
    input  logic [DW-1:0]        valu_res_i,
    input  logic                 enableMem_i,
    input  logic                 enableReg_i,
    input  logic                 flagMemRead_i,
    input  logic                 flagMemWrite_i,
    input  logic                 isOper2V_i,
    input  logic                 writeResultInt_i,
    input  logic                 writeResultV_i,
    output logic [AW-1:0]        mem_addr_o,
    output logic [ELEM_SIZE-1:0] mem_wdata_o,
    output logic                 mem_we_o,
    output logic                 mem_re_o,
    input  logic [ELEM_SIZE-1:0] mem_rdata_i,
    output logic                 stall_o,
    output logic                 wb_valid_o,
    output logic [REGI_SIZE-1:0] wb_int_res_o,
    output logic [DW-1:0]        wb_vec_res_o,
    output logic                 wb_we_int_o,
    output logic                 wb_we_vec_o
);

    localparam int CW = $clog2(VECT_SIZE + 1);
    localparam int IW = $clog2(VECT_SIZE);

    memst_e state_q;
    memst_e state_d;

    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        n_q;
    logic [AW-1:0]        base_q;
    logic [REGI_SIZE-1:0] ialu_q;
    logic [DW-1:0]        valu_q;
    logic                 we_int_q;
    logic                 we_vec_q;
    logic [ELEM_SIZE-1:0] buf_q [VECT_SIZE];

    logic                 memop;
    logic                 last;
    logic [CW-1:0]        last_idx;
    logic [ELEM_SIZE-1:0] wbyte;
    logic [DW-1:0]        ld_vec;
    logic                 vec_sel;

    assign memop    = enableMem_i & (flagMemRead_i | flagMemWrite_i);
    assign last_idx = n_q - CW'(1);
    assign last     = (cnt_q == last_idx);
    // Write wins over read when both flags are set.
    assign vec_sel  = flagMemWrite_i ? isOper2V_i : writeResultV_i;

    always_comb begin
        wbyte = '0;
        for (int k = 0; k < VECT_SIZE; k++) begin
            if (CW'(k) == cnt_q) begin
                wbyte = valu_q[k*ELEM_SIZE +: ELEM_SIZE];
            end
        end
    end

    // The final byte arrives during RDRAIN and is merged on the fly.
    always_comb begin
        ld_vec = '0;
        for (int k = 0; k < VECT_SIZE; k++) begin
            if (state_q == ST_RDRAIN && CW'(k) == last_idx) begin
                ld_vec[k*ELEM_SIZE +: ELEM_SIZE] = mem_rdata_i;
            end else begin
                ld_vec[k*ELEM_SIZE +: ELEM_SIZE] = buf_q[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_wdata_o = '0;
        mem_addr_o  = AW'(addr_wrap(16'(base_q), 16'(cnt_q)));
        unique case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    stall_o = 1'b1;
                    state_d = flagMemWrite_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                stall_o     = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = wbyte;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                stall_o  = 1'b1;
                mem_re_o = 1'b1;
                if (last) begin
                    state_d = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                stall_o = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            n_q          <= '0;
            base_q       <= '0;
            ialu_q       <= '0;
            valu_q       <= '0;
            we_int_q     <= 1'b0;
            we_vec_q     <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_int_res_o <= '0;
            wb_vec_res_o <= '0;
            wb_we_int_o  <= 1'b0;
            wb_we_vec_o  <= 1'b0;
            for (int k = 0; k < VECT_SIZE; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (memop) begin
                        base_q      <= ialu_res_i[AW-1:0];
                        ialu_q      <= ialu_res_i;
                        valu_q      <= valu_res_i;
                        n_q         <= vec_sel ? CW'(VECT_SIZE)
                                               : CW'(SCALAR_BYTES);
                        we_int_q    <= enableReg_i & writeResultInt_i;
                        we_vec_q    <= enableReg_i & writeResultV_i;
                        cnt_q       <= '0;
                        wb_valid_o  <= 1'b0;
                        wb_we_int_o <= 1'b0;
                        wb_we_vec_o <= 1'b0;
                        for (int k = 0; k < VECT_SIZE; k++) begin
                            buf_q[k] <= '0;
                        end
                    end else begin
                        wb_valid_o   <= enableReg_i;
                        wb_int_res_o <= ialu_res_i;
                        wb_vec_res_o <= valu_res_i;
                        wb_we_int_o  <= enableReg_i & writeResultInt_i;
                        wb_we_vec_o  <= enableReg_i & writeResultV_i;
                    end
                end
                ST_WRITE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        wb_valid_o   <= 1'b1;
                        wb_int_res_o <= ialu_q;
                        wb_vec_res_o <= valu_q;
                        wb_we_int_o  <= we_int_q;
                        wb_we_vec_o  <= we_vec_q;
                    end
                end
                ST_READ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q != '0) begin
                        buf_q[IW'(cnt_q - CW'(1))] <= mem_rdata_i;
                    end
                end
                ST_RDRAIN: begin
                    buf_q[IW'(last_idx)] <= mem_rdata_i;
                    wb_valid_o   <= 1'b1;
                    wb_int_res_o <= ld_vec[REGI_SIZE-1:0];
                    wb_vec_res_o <= ld_vec;
                    wb_we_int_o  <= we_int_q;
                    wb_we_vec_o  <= we_vec_q;
                end
                ST_DONE: begin
                    wb_valid_o  <= 1'b0;
                    wb_we_int_o <= 1'b0;
                    wb_we_vec_o <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: per-cycle timeline model plus
// a byte memory, directed literal cases and randomized instruction streams.
module tb_mem_stage_ctrl;

    localparam int ML = 64;
    localparam int VS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ialu;
    logic [63:0] valu;
    logic        en_mem, en_reg, rd, wr, op2v, wri, wrv;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  rdata = 8'h00;
    logic        stall;
    logic        wb_valid;
    logic [15:0] wb_int;
    logic [63:0] wb_vec;
    logic        wb_we_int, wb_we_vec;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .ialu_res_i(ialu), .valu_res_i(valu),
        .enableMem_i(en_mem), .enableReg_i(en_reg),
        .flagMemRead_i(rd), .flagMemWrite_i(wr),
        .isOper2V_i(op2v),
        .writeResultInt_i(wri), .writeResultV_i(wrv),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_rdata_i(rdata), .stall_o(stall),
        .wb_valid_o(wb_valid), .wb_int_res_o(wb_int),
        .wb_vec_res_o(wb_vec),
        .wb_we_int_o(wb_we_int), .wb_we_vec_o(wb_we_vec)
    );

    typedef struct {
        bit rst; logic [15:0] ialu; logic [63:0] valu;
        bit en_mem, en_reg, rd, wr, op2v, wri, wrv;
    } in_t;

    typedef struct {
        bit v, chk, wi, wv; logic [15:0] i; logic [63:0] vv;
    } wb_t;

    typedef struct {
        bit stall, we, re; logic [5:0] addr; logic [7:0] wdata; wb_t wb;
    } exp_t;

    exp_t        exq[$];
    wb_t         pend;
    logic [7:0]  ref_mem [ML];
    logic [7:0]  mem [ML];
    bit          seeded = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          re_cnt = 0;
    int          wb_cnt = 0;
    logic [15:0] last_int;
    logic [63:0] last_vec;
    logic        last_wev;

    function automatic logic [7:0] seed_byte(input int a);
        if (a >= 16 && a < 24) return 8'(a - 15);
        return 8'(a * 37 + 11);
    endfunction

    always @(posedge clk) begin
        if (!seeded) begin
            for (int a = 0; a < ML; a++) mem[a] <= seed_byte(a);
            seeded <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exq.size() != 0) begin
            exp_t e;
            e = exq.pop_front();
            chk("stall", 64'(stall), 64'(e.stall));
            chk("mem_we", 64'(mem_we), 64'(e.we));
            chk("mem_re", 64'(mem_re), 64'(e.re));
            if (e.we || e.re) chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
            chk("wb_valid", 64'(wb_valid), 64'(e.wb.v));
            if (e.wb.chk) begin
                chk("wb_int", 64'(wb_int), 64'(e.wb.i));
                chk("wb_vec", wb_vec, e.wb.vv);
                chk("wb_we_int", 64'(wb_we_int), 64'(e.wb.wi));
                chk("wb_we_vec", 64'(wb_we_vec), 64'(e.wb.wv));
            end
        end
        if (mem_re) re_cnt++;
        if (wb_valid) begin
            wb_cnt++;
            last_int = wb_int;
            last_vec = wb_vec;
            last_wev = wb_we_vec;
        end
    end

    function automatic wb_t wb_none();
        wb_t w;
        w = '{default: '0};
        return w;
    endfunction

    function automatic in_t idle_in();
        in_t x;
        x = '{default: '0};
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.rst = 1'b0;
        x.ialu = 16'($urandom);
        x.valu = {$urandom, $urandom};
        x.en_mem = 1'($urandom); x.en_reg = 1'($urandom);
        x.rd = 1'($urandom); x.wr = 1'($urandom);
        x.op2v = 1'($urandom); x.wri = 1'($urandom);
        x.wrv = 1'($urandom);
        return x;
    endfunction

    function automatic exp_t mk(bit st, bit we, bit re, logic [5:0] a,
                                logic [7:0] d, wb_t w);
        exp_t e;
        e.stall = st; e.we = we; e.re = re;
        e.addr = a; e.wdata = d; e.wb = w;
        return e;
    endfunction

    task automatic step(input in_t x, input exp_t e);
        @(posedge clk);
        #1;
        rst = x.rst; ialu = x.ialu; valu = x.valu;
        en_mem = x.en_mem; en_reg = x.en_reg; rd = x.rd; wr = x.wr;
        op2v = x.op2v; wri = x.wri; wrv = x.wrv;
        exq.push_back(e);
    endtask

    // One instruction from the cycle it is presented to its DONE cycle.
    task automatic run_instr(input in_t x, input int abort_beat);
        bit          memop, is_wr;
        int          n;
        in_t         j;
        wb_t         w;
        logic [63:0] ld;
        logic [5:0]  a;
        memop = x.en_mem & (x.rd | x.wr);
        if (!memop) begin
            step(x, mk(0, 0, 0, 0, 0, pend));
            pend.v = x.en_reg; pend.chk = x.en_reg;
            pend.i = x.ialu; pend.vv = x.valu;
            pend.wi = x.en_reg & x.wri; pend.wv = x.en_reg & x.wrv;
            return;
        end
        is_wr = x.wr;
        n = (is_wr ? x.op2v : x.wrv) ? VS : 2;
        step(x, mk(1, 0, 0, 0, 0, pend));
        pend = wb_none();
        ld = '0;
        for (int i = 0; i < n; i++) begin
            a = 6'((int'(x.ialu) + i) % ML);
            j = rand_in();
            j.rst = (i == abort_beat);
            step(j, mk(1, is_wr, !is_wr, a, x.valu[i*8 +: 8], wb_none()));
            if (is_wr) ref_mem[a] = x.valu[i*8 +: 8];
            else ld[i*8 +: 8] = ref_mem[a];
            if (i == abort_beat) begin
                w = wb_none();
                w.chk = 1'b1;
                step(idle_in(), mk(0, 0, 0, 0, 0, w));
                pend = wb_none();
                return;
            end
        end
        if (!is_wr) step(rand_in(), mk(1, 0, 0, 0, 0, wb_none()));
        w.v = 1'b1; w.chk = 1'b1;
        w.i = is_wr ? x.ialu : ld[15:0];
        w.vv = is_wr ? x.valu : ld;
        w.wi = x.en_reg & x.wri; w.wv = x.en_reg & x.wrv;
        step(rand_in(), mk(0, 0, 0, 0, 0, w));
        pend = wb_none();
    endtask

    initial begin
        in_t        x;
        wb_t        w;
        int         r0, w0, mism;
        logic [7:0] saved [4];

        for (int a = 0; a < ML; a++) ref_mem[a] = seed_byte(a);
        pend = wb_none();
        rst = 1'b1; ialu = '0; valu = '0;
        en_mem = 0; en_reg = 0; rd = 0; wr = 0;
        op2v = 0; wri = 0; wrv = 0;
        repeat (2) @(posedge clk);
        w = wb_none();
        w.chk = 1'b1;
        step(idle_in(), mk(0, 0, 0, 0, 0, w));

        x = idle_in();
        x.en_reg = 1; x.wri = 1; x.ialu = 16'h1234;
        run_instr(x, -1);
        run_instr(idle_in(), -1);
        @(negedge clk); #1;
        chk("lit_nonmem_int", 64'(last_int), 64'h1234);

        w0 = wb_cnt;
        x = idle_in();
        x.en_mem = 1; x.wr = 1; x.ialu = 16'h003F;
        x.valu = 64'h1122_3344_5566_BEEF;
        run_instr(x, -1);
        @(negedge clk); #1;
        chk("lit_sst_mem3f", 64'(mem[6'h3F]), 64'hEF);
        chk("lit_sst_mem00", 64'(mem[6'h00]), 64'hBE);
        chk("lit_sst_wbcnt", 64'(wb_cnt - w0), 64'd1);

        x = idle_in();
        x.en_mem = 1; x.rd = 1; x.wrv = 1; x.en_reg = 1;
        x.ialu = 16'h0010;
        run_instr(x, -1);
        @(negedge clk); #1;
        chk("lit_vld_vec", last_vec, 64'h0807_0605_0403_0201);
        chk("lit_vld_wev", 64'(last_wev), 64'd1);

        r0 = re_cnt;
        x = idle_in();
        x.en_mem = 1; x.rd = 1; x.wr = 1; x.op2v = 1;
        x.ialu = 16'h0030; x.valu = 64'hA5A5_5A5A_0F0F_F0F0;
        run_instr(x, -1);
        @(negedge clk); #1;
        chk("lit_rw_no_re", 64'(re_cnt - r0), 64'd0);

        for (int k = 0; k < 4; k++) saved[k] = mem[6'h24 + 6'(k)];
        w0 = wb_cnt;
        x = idle_in();
        x.en_mem = 1; x.wr = 1; x.op2v = 1; x.en_reg = 1; x.wrv = 1;
        x.ialu = 16'h0020; x.valu = 64'hDEAD_BEEF_CAFE_F00D;
        run_instr(x, 3);
        @(negedge clk); #1;
        chk("lit_abort_wbcnt", 64'(wb_cnt - w0), 64'd0);
        for (int k = 0; k < 4; k++)
            chk("lit_abort_untouched", 64'(mem[6'h24 + 6'(k)]), 64'(saved[k]));

        w0 = wb_cnt;
        x = idle_in();
        x.en_mem = 1; x.rd = 1; x.en_reg = 1; x.wri = 1;
        x.ialu = 16'h003F;
        run_instr(x, -1);
        x = idle_in();
        x.en_mem = 1; x.wr = 1; x.op2v = 1; x.ialu = 16'h003C;
        x.valu = 64'h0102_0304_0506_0708;
        run_instr(x, -1);
        @(negedge clk); #1;
        chk("lit_b2b_wbcnt", 64'(wb_cnt - w0), 64'd2);

        for (int t = 0; t < 300; t++) begin
            x = rand_in();
            x.en_mem = ($urandom_range(0, 9) < 6);
            run_instr(x, -1);
        end
        run_instr(idle_in(), -1);
        run_instr(idle_in(), -1);
        @(negedge clk); #1;

        mism = 0;
        for (int a = 0; a < ML; a++)
            if (mem[a] !== ref_mem[a]) mism++;
        chk("mem_final", 64'(mism), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller that consumes the EX/MEM pipeline-register bundle: integer ALU result as address, vector ALU result as store data, plus mem/reg enables and result-type flags.
- Sequences scalar (2-byte) or vector (VECT_SIZE-byte) loads and stores onto a byte-wide, MEMO_LINES-deep data memory.
- Stalls the upstream pipeline while an access is in flight, then emits a registered writeback bundle.

Parameters:
- MEMO_LINES, 64, data memory depth in bytes; address width AW = $clog2(MEMO_LINES).
- REGI_SIZE, 16, integer register width; scalar access = REGI_SIZE/ELEM_SIZE = 2 bytes.
- VECT_SIZE, 8, elements per vector; vector access = VECT_SIZE bytes.
- ELEM_SIZE, 8, element width and memory data width.

Ports:
- clk_i  in  1  clock (single clock domain).
- rst_i  in  1  reset, synchronous, active-high.
- ialu_res_i  in  REGI_SIZE  access base address (low AW bits used).
- valu_res_i  in  ELEM_SIZE*VECT_SIZE  store data; byte i = bits [8i+7:8i].
- enableMem_i, enableReg_i  in  1 each  memory op valid; register writeback valid.
- flagMemRead_i, flagMemWrite_i  in  1 each  load / store.
- isOper2V_i  in  1  store size: 1 = vector, 0 = scalar.
- writeResultInt_i, writeResultV_i  in  1 each  writeback targets integer / vector register file.
- mem_addr_o  out  AW  memory byte address.
- mem_wdata_o  out  ELEM_SIZE  memory write data.
- mem_we_o, mem_re_o  out  1 each  write / read strobes.
- mem_rdata_i  in  ELEM_SIZE  read data; valid exactly one cycle after mem_re_o.
- stall_o  out  1  upstream pipeline register holds its contents while high.
- wb_valid_o  out  1  writeback bundle valid; one-cycle pulse per instruction.
- wb_int_res_o  out  REGI_SIZE  integer writeback value.
- wb_vec_res_o  out  ELEM_SIZE*VECT_SIZE  vector writeback value.
- wb_we_int_o, wb_we_vec_o  out  1 each  register-file write enables.

Behaviour:
- Reset (rst_i at a clock edge):
  - State goes to IDLE; beat counter and assembly buffer clear.
  - All wb_* outputs become 0.
  - mem_we_o, mem_re_o, and stall_o are 0 in IDLE with no memory op at the input.
  - Reset mid-access abandons the access: no further strobes and no wb_valid_o.
- States: IDLE, WRITE, READ, RDRAIN, DONE.
- Memory op definition: memop = enableMem_i & (flagMemRead_i | flagMemWrite_i).
  - If both read and write flags are set, the write wins and the read is ignored.
- Transfer length N: stores use isOper2V_i; loads use writeResultV_i. Vector gives N = VECT_SIZE, scalar gives N = 2.
- IDLE:
  - memop = 0: register the bundle with 1-cycle latency.
    - wb_valid_o = enableReg_i; wb_int_res_o = ialu_res_i; wb_vec_res_o = valu_res_i.
    - wb_we_int_o = enableReg_i & writeResultInt_i; wb_we_vec_o = enableReg_i & writeResultV_i.
  - memop = 1: stall_o = 1 combinationally in the same cycle.
    - Latch address, data, flags and N; set counter i = 0.
    - Go to WRITE or READ; wb_valid_o = 0 next cycle.
- stall_o = 1 in WRITE, READ and RDRAIN, and in IDLE when memop = 1. stall_o = 0 in DONE.
  - Upstream advances on the edge that leaves DONE.
  - Inputs are ignored in every state except IDLE.
- WRITE: for each beat i = 0..N-1:
  - mem_we_o = 1; mem_addr_o = (base + i) mod MEMO_LINES (natural AW-bit wrap); mem_wdata_o = latched byte i.
  - After beat N-1, go to DONE. Total N+1 cycles from accept to DONE.
- READ: for each beat i = 0..N-1:
  - mem_re_o = 1 with the same address rule.
  - mem_rdata_i captured in cycle i+1 goes to buffer byte i; little-endian, byte 0 = LSB.
  - After beat N-1, go to RDRAIN to capture the last byte, then DONE.
- DONE: one cycle, then IDLE.
  - On entry, wb_valid_o pulses 1 for this cycle.
  - Load: wb_int_res_o = buffer[15:0] and wb_vec_res_o = full buffer. Unused upper bytes are 0 for scalar loads.
  - Store: wb outputs carry the latched ialu/valu values.
  - wb_we_int_o / wb_we_vec_o = latched enableReg & writeResultInt / writeResultV.
- mem_we_o and mem_re_o are never high together, and neither is high outside WRITE/READ.
- Back-to-back memory ops: the second op is accepted in the IDLE cycle directly after DONE. No bubble beyond DONE.

Decomposition:
- Shared package mem_pkg:
  - State enum memst_e.
  - Constants SCALAR_BYTES = 2 and VEC_BYTES = VECT_SIZE.
  - Function addr_wrap(base, i).
- No sub-module needed. The read assembly buffer stays inline as a byte-indexed register array.

Test Plan:
- Non-mem op: enableReg=1, writeResultInt=1, ialu=0x1234 → next cycle wb_valid=1, wb_int_res=0x1234, wb_we_int=1, stall_o never high.
- Scalar store: base=0x3F, valu=0x..BEEF → mem_we on 2 cycles: addr 0x3F data 0xEF, then addr 0x00 data 0xBE. stall_o high 3 cycles, then DONE with wb_valid=1.
- Vector load: base=0x10, memory 0x10..0x17 = 0x01..0x08 → mem_re on 8 cycles, wb_vec_res=0x0807060504030201 after 10 cycles, wb_we_vec=1.
- Read+write both set: write executes, no mem_re_o pulse.
- Reset asserted during beat 3 of a vector store → from next cycle mem_we=0, state IDLE, wb_valid never pulses, memory bytes 4..7 untouched.
- Back-to-back: scalar load then vector store → strobes never overlap, exactly two wb_valid pulses, second op accepted in the cycle after the first DONE.
